// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// The master side issues the operation and flush; the slave side returns busy, done, result and rd_out.
interface muldiv_unit_if #(
  parameter int N = 32
);
  logic         start;
  logic [2:0]   funct3;
  logic [N-1:0] rs1_data;
  logic [N-1:0] rs2_data;
  logic [4:0]   rd_in;
  logic         flush;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic [4:0]   rd_out;

  modport master (
    output start, funct3, rs1_data, rs2_data, rd_in, flush,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, rd_in, flush,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide; FAST_MUL_EN selects a single-cycle combinational multiplier.
// Latency N+1 edges after accept (2 for special cases); start is ignored while busy, flush aborts.
module muldiv_unit #(
  parameter int N = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam int             CW   = $clog2(N + 1);
  localparam logic [CW-1:0]  LAST = CW'(N);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    op;
  logic [4:0]    rd_q;
  logic          neg_p;
  logic          neg_a;
  logic          skip_q;
  logic [N-1:0]  mb;
  logic [N-1:0]  acc_hi;
  logic [N-1:0]  acc_lo;
  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  result_q;
  logic [4:0]    rd_out_q;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

  // Operand decode at accept
  logic         a_sgn, b_sgn, a_neg, b_neg;
  logic [N-1:0] a_mag, b_mag;
  logic         div_zero, div_ovf, skip;
  logic [N-1:0] spec_val, skip_val;

  always_comb begin
    a_sgn    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
               (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    b_sgn    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
               (bus.funct3 == 3'b110);
    a_neg    = a_sgn & bus.rs1_data[N-1];
    b_neg    = b_sgn & bus.rs2_data[N-1];
    a_mag    = a_neg ? (~bus.rs1_data + 1'b1) : bus.rs1_data;
    b_mag    = b_neg ? (~bus.rs2_data + 1'b1) : bus.rs2_data;
    div_zero = bus.funct3[2] && (bus.rs2_data == '0);
    div_ovf  = ((bus.funct3 == 3'b100) || (bus.funct3 == 3'b110)) &&
               (bus.rs1_data == {1'b1, {(N-1){1'b0}}}) && (bus.rs2_data == '1);
    if (div_zero)
      spec_val = bus.funct3[1] ? bus.rs1_data : '1;
    else
      spec_val = bus.funct3[1] ? '0 : bus.rs1_data;
  end

`ifdef FAST_MUL_EN
  logic [2*N-1:0] fa, fb, fprod;
  logic [N-1:0]   fast_val;

  always_comb begin
    fa       = {{N{a_neg}}, bus.rs1_data};
    fb       = {{N{b_neg}}, bus.rs2_data};
    fprod    = fa * fb;
    fast_val = (bus.funct3 == 3'b000) ? fprod[N-1:0] : fprod[2*N-1:N];
    skip     = div_zero | div_ovf | ~bus.funct3[2];
    skip_val = bus.funct3[2] ? spec_val : fast_val;
  end
`else
  always_comb begin
    skip     = div_zero | div_ovf;
    skip_val = spec_val;
  end
`endif

  // One iteration of each datapath plus the sign-corrected final value
  logic [N:0]     msum;
  logic [N:0]     shifted, diff;
  logic           ge;
  logic [2*N-1:0] prod, prod_s;
  logic [N-1:0]   fin_val;

  always_comb begin
    msum    = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mb : {N{1'b0}})};
    shifted = {acc_hi, acc_lo[N-1]};
    diff    = shifted - {1'b0, mb};
    ge      = ~diff[N];
    prod    = {acc_hi, acc_lo};
    prod_s  = neg_p ? (~prod + 1'b1) : prod;
    if (skip_q)
      fin_val = acc_lo;
    else if (op[2] && op[1])
      fin_val = neg_a ? (~acc_hi + 1'b1) : acc_hi;
    else if (op[2])
      fin_val = neg_p ? (~acc_lo + 1'b1) : acc_lo;
    else if (op == 3'b000)
      fin_val = prod_s[N-1:0];
    else
      fin_val = prod_s[2*N-1:N];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= '0;
      rd_q     <= '0;
      neg_p    <= 1'b0;
      neg_a    <= 1'b0;
      skip_q   <= 1'b0;
      mb       <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else if (bus.flush) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (state)
        // DONE also accepts so a start raised in the done cycle issues back-to-back
        IDLE, DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
          if (bus.start) begin
            op     <= bus.funct3;
            rd_q   <= bus.rd_in;
            neg_p  <= a_neg ^ b_neg;
            neg_a  <= a_neg;
            skip_q <= skip;
            busy_q <= 1'b1;
            mb     <= bus.funct3[2] ? b_mag : a_mag;
            acc_hi <= '0;
            acc_lo <= skip ? skip_val : (bus.funct3[2] ? a_mag : b_mag);
            cnt    <= skip ? (LAST - 1'b1) : '0;
            state  <= (skip || bus.funct3[2]) ? DIV : MUL;
          end
        end
        MUL, DIV: begin
          if (cnt == LAST) begin
            result_q <= fin_val;
            rd_out_q <= rd_q;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
            if (!skip_q) begin
              if (state == MUL) begin
                {acc_hi, acc_lo} <= {msum, acc_lo[N-1:1]};
              end else begin
                acc_hi <= ge ? diff[N-1:0] : shifted[N-1:0];
                acc_lo <= {acc_lo[N-2:0], ge};
              end
            end
          end
        end
      endcase
    end
  end

endmodule
